// File: rtl/vga_pattern_out_pkg.sv
// ============================================================================
//  vga_pattern_out_pkg
//  Shared types, constants and colour helpers for the VGA pattern generator.
//  Revision: 1.0
// ============================================================================
`include "vga_800x600.vh"
`default_nettype none

package vga_pattern_out_pkg;

    localparam int unsigned c_H_ACTIVE     = `VGA_H_ACTIVE;
    localparam int unsigned c_H_SYNC_START = `VGA_H_SYNC_START;
    localparam int unsigned c_H_SYNC_END   = `VGA_H_SYNC_END;
    localparam int unsigned c_V_ACTIVE     = `VGA_V_ACTIVE;
    localparam int unsigned c_V_SYNC_START = `VGA_V_SYNC_START;
    localparam int unsigned c_V_SYNC_END   = `VGA_V_SYNC_END;

    localparam logic [10:0] c_BAR_WIDTH       = 11'd100;
    localparam logic [5:0]  c_PHASE_LAST_FRM  = 6'd59;
    localparam logic [3:0]  c_BOX_BG_BLUE     = 4'h4;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_BOX      = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    typedef enum logic [0:0] {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } xdir_e;

    typedef enum logic [0:0] {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } ydir_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Bar 0 is white, bar 7 black: colour bits come from the inverted index.
    function automatic rgb_t bar_colour(input logic [2:0] index);
        logic [2:0] bits;
        rgb_t       c;
        bits = 3'd7 - index;
        c.r  = {4{bits[2]}};
        c.g  = {4{bits[1]}};
        c.b  = {4{bits[0]}};
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_800x600.vh
// ============================================================================
//  vga_800x600.vh
//  Shared 800x600@60 timing constants for the timing generator and pattern out.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`ifndef VGA_800X600_VH
`define VGA_800X600_VH

`define VGA_H_ACTIVE      800
`define VGA_H_SYNC_START  840
`define VGA_H_SYNC_END    968
`define VGA_H_TOTAL       1056
`define VGA_V_ACTIVE      600
`define VGA_V_SYNC_START  601
`define VGA_V_SYNC_END    605
`define VGA_V_TOTAL       628

`endif
`default_nettype wire

// File: rtl/vga_box_mover.sv
// ============================================================================
//  vga_box_mover
//  Bouncing-box position: one pixel per axis per frame event, reversing at edges.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module vga_box_mover
    import vga_pattern_out_pkg::*;
#(
    parameter int unsigned X_MAX = 736,
    parameter int unsigned Y_MAX = 536
) (
    input  logic        i_pixclock,
    input  logic        i_reset_n,
    input  logic        i_frame_evt,
    output logic [10:0] o_box_x,
    output logic [9:0]  o_box_y
);

    localparam logic [10:0] c_x_max = 11'(X_MAX);
    localparam logic [9:0]  c_y_max = 10'(Y_MAX);

    xdir_e       xdir_q;
    ydir_e       ydir_q;
    logic [10:0] box_x_q;
    logic [9:0]  box_y_q;

    // Reversal and the step happen in the same update so position stays in range.
    always_ff @(posedge i_pixclock) begin
        if (!i_reset_n) begin
            xdir_q  <= DIR_RIGHT;
            ydir_q  <= DIR_DOWN;
            box_x_q <= '0;
            box_y_q <= '0;
        end else if (i_frame_evt) begin
            unique case (xdir_q)
                DIR_RIGHT: begin
                    if (box_x_q == c_x_max) begin
                        xdir_q  <= DIR_LEFT;
                        box_x_q <= box_x_q - 11'd1;
                    end else begin
                        box_x_q <= box_x_q + 11'd1;
                    end
                end
                DIR_LEFT: begin
                    if (box_x_q == 11'd0) begin
                        xdir_q  <= DIR_RIGHT;
                        box_x_q <= box_x_q + 11'd1;
                    end else begin
                        box_x_q <= box_x_q - 11'd1;
                    end
                end
            endcase
            unique case (ydir_q)
                DIR_DOWN: begin
                    if (box_y_q == c_y_max) begin
                        ydir_q  <= DIR_UP;
                        box_y_q <= box_y_q - 10'd1;
                    end else begin
                        box_y_q <= box_y_q + 10'd1;
                    end
                end
                DIR_UP: begin
                    if (box_y_q == 10'd0) begin
                        ydir_q  <= DIR_DOWN;
                        box_y_q <= box_y_q + 10'd1;
                    end else begin
                        box_y_q <= box_y_q - 10'd1;
                    end
                end
            endcase
        end
    end

    assign o_box_x = box_x_q;
    assign o_box_y = box_y_q;

endmodule

`default_nettype wire

// File: rtl/vga_pattern_out.sv
// ============================================================================
//  vga_pattern_out
//  Two-stage pipelined VGA test-pattern generator with frame-latched mode.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module vga_pattern_out
    import vga_pattern_out_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = c_H_ACTIVE,
    parameter int unsigned V_ACTIVE     = c_V_ACTIVE,
    parameter int unsigned H_SYNC_START = c_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = c_H_SYNC_END,
    parameter int unsigned V_SYNC_START = c_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = c_V_SYNC_END,
    parameter int unsigned BOX_SIZE     = 64
) (
    input  logic        i_pixclock,
    input  logic        i_reset_n,
    input  logic [10:0] i_hcount,
    input  logic [9:0]  i_vcount,
    input  logic [1:0]  i_mode,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic        o_frame
);

    localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
    localparam logic [10:0] c_hs_start = 11'(H_SYNC_START);
    localparam logic [10:0] c_hs_end   = 11'(H_SYNC_END);
    localparam logic [9:0]  c_v_active = 10'(V_ACTIVE);
    localparam logic [9:0]  c_vs_start = 10'(V_SYNC_START);
    localparam logic [9:0]  c_vs_end   = 10'(V_SYNC_END);
    localparam logic [11:0] c_box_w    = 12'(BOX_SIZE);
    localparam logic [10:0] c_box_h    = 11'(BOX_SIZE);

    logic        w_frame_evt;
    logic [10:0] w_box_x;
    logic [9:0]  w_box_y;
    logic [2:0]  w_bar_idx;
    logic        w_in_box;

    logic        valid_q;
    logic        active_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        frame_q;
    logic [10:0] hcount_q;
    logic [9:0]  vcount_q;

    mode_e       mode_q;
    logic [5:0]  frame_cnt_q;
    logic        phase_q;
    rgb_t        pixel_d;

    assign w_frame_evt = (i_hcount == 11'd0) && (i_vcount == c_v_active);

    vga_box_mover #(
        .X_MAX (H_ACTIVE - BOX_SIZE),
        .Y_MAX (V_ACTIVE - BOX_SIZE)
    ) u_box_mover (
        .i_pixclock  (i_pixclock),
        .i_reset_n   (i_reset_n),
        .i_frame_evt (w_frame_evt),
        .o_box_x     (w_box_x),
        .o_box_y     (w_box_y)
    );

    // Stage 1: registered counters and region/sync flags.
    always_ff @(posedge i_pixclock) begin
        if (!i_reset_n) begin
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            frame_q  <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            valid_q  <= 1'b1;
            active_q <= (i_hcount < c_h_active) && (i_vcount < c_v_active);
            hsync_q  <= (i_hcount >= c_hs_start) && (i_hcount < c_hs_end);
            vsync_q  <= (i_vcount >= c_vs_start) && (i_vcount < c_vs_end);
            frame_q  <= w_frame_evt;
            hcount_q <= i_hcount;
            vcount_q <= i_vcount;
        end
    end

    // Frame-rate state: mode only changes at the frame event so a frame never tears.
    always_ff @(posedge i_pixclock) begin
        if (!i_reset_n) begin
            mode_q      <= MODE_BARS;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (w_frame_evt) begin
            mode_q <= mode_e'(i_mode);
            if (frame_cnt_q == c_PHASE_LAST_FRM) begin
                frame_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 6'd1;
            end
        end
    end

    assign w_bar_idx = 3'(hcount_q / c_BAR_WIDTH);
    assign w_in_box  = (hcount_q >= w_box_x)
                    && ({1'b0, hcount_q} < ({1'b0, w_box_x} + c_box_w))
                    && (vcount_q >= w_box_y)
                    && ({1'b0, vcount_q} < ({1'b0, w_box_y} + c_box_h));

    always_comb begin
        pixel_d = '0;
        if (active_q) begin
            unique case (mode_q)
                MODE_BARS:    pixel_d = bar_colour(w_bar_idx);
                MODE_CHECKER: pixel_d = {12{hcount_q[5] ^ vcount_q[5] ^ phase_q}};
                MODE_BOX:     pixel_d = w_in_box ? 12'hFFF : {8'h00, c_BOX_BG_BLUE};
                MODE_GRADIENT: begin
                    pixel_d.r = hcount_q[9:6];
                    pixel_d.g = hcount_q[9:6];
                    pixel_d.b = hcount_q[9:6];
                end
            endcase
        end
    end

    // Stage 2: output registers.
    always_ff @(posedge i_pixclock) begin
        if (!i_reset_n) begin
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_frame <= 1'b0;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
        end else begin
            o_hsync <= valid_q & hsync_q;
            o_vsync <= valid_q & vsync_q;
            o_frame <= valid_q & frame_q;
            {o_red, o_green, o_blue} <= valid_q ? pixel_d : 12'h000;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_out.sv
// ============================================================================
//  tb_vga_pattern_out
//  Scoreboard bench for vga_pattern_out with an independent pixel model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_pattern_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [1:0]  mode = '0;
    logic        o_hsync, o_vsync, o_frame;
    logic [3:0]  o_red, o_green, o_blue;

    always #5 clk = ~clk;

    vga_pattern_out dut (
        .i_pixclock (clk),
        .i_reset_n  (rst_n),
        .i_hcount   (hcount),
        .i_vcount   (vcount),
        .i_mode     (mode),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_red      (o_red),
        .o_green    (o_green),
        .o_blue     (o_blue),
        .o_frame    (o_frame)
    );

    typedef struct {
        logic [14:0] exp;
        bit          tally;
    } sb_t;

    sb_t        sb_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_events = 0;
    logic [1:0] m_mode = 2'd0;
    int         hs_tally = 0;
    int         vs_tally = 0;
    int         fr_tally = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Triangle wave: position after n frame events on an axis bouncing in [0, span].
    function automatic int tri_pos(input int n, input int span);
        int p;
        p = n % (2 * span);
        return (p <= span) ? p : (2 * span - p);
    endfunction

    function automatic logic [14:0] model(input logic rn, input int h, input int v,
                                          input int n, input logic [1:0] md);
        logic       hs, vs, fr, w;
        logic [3:0] r, g, b;
        logic [2:0] bar;
        int         bx, by;
        if (!rn) return 15'h0;
        hs = (h >= 840) && (h < 968);
        vs = (v >= 601) && (v < 605);
        fr = (h == 0) && (v == 600);
        r = 4'h0; g = 4'h0; b = 4'h0;
        if (h < 800 && v < 600) begin
            case (md)
                2'd0: begin
                    bar = 3'(7 - h / 100);
                    r = bar[2] ? 4'hF : 4'h0;
                    g = bar[1] ? 4'hF : 4'h0;
                    b = bar[0] ? 4'hF : 4'h0;
                end
                2'd1: begin
                    w = 1'(((h >> 5) ^ (v >> 5) ^ (n / 60)) & 1);
                    r = {4{w}}; g = r; b = r;
                end
                2'd2: begin
                    bx = tri_pos(n, 736);
                    by = tri_pos(n, 536);
                    if (h >= bx && h < bx + 64 && v >= by && v < by + 64) {r, g, b} = 12'hFFF;
                    else {r, g, b} = 12'h004;
                end
                default: begin
                    r = 4'((h >> 6) & 15); g = r; b = r;
                end
            endcase
        end
        return {hs, vs, fr, r, g, b};
    endfunction

    task automatic tick(input bit drain);
        sb_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 2 || (drain && sb_q.size() > 0)) begin
            e = sb_q.pop_front();
            check_eq("sync", 32'({o_hsync, o_vsync, o_frame}), 32'(e.exp[14:12]));
            check_eq("rgb", 32'({o_red, o_green, o_blue}), 32'(e.exp[11:0]));
            if (e.tally) begin
                hs_tally += int'(o_hsync);
                vs_tally += int'(o_vsync);
                fr_tally += int'(o_frame);
            end
        end
    endtask

    task automatic drive(input logic rn, input int h, input int v, input logic [1:0] md, input bit tally);
        sb_t e;
        tick(1'b0);
        rst_n  = rn;
        hcount = 11'(h);
        vcount = 10'(v);
        mode   = md;
        if (!rn) begin
            // Reset also clears the output registers holding the previous pixel.
            if (sb_q.size() > 0) sb_q[sb_q.size() - 1].exp = 15'h0;
            n_events = 0;
            m_mode   = 2'd0;
        end else if (h == 0 && v == 600) begin
            n_events++;
            m_mode = md;
        end
        e.exp   = model(rn, h, v, n_events, m_mode);
        e.tally = tally;
        sb_q.push_back(e);
    endtask

    task automatic probe_box(input logic [1:0] md);
        int bx, by;
        bx = tri_pos(n_events, 736);
        by = tri_pos(n_events, 536);
        drive(1'b1, bx, by, md, 1'b0);
        drive(1'b1, bx + 63, by + 63, md, 1'b0);
        drive(1'b1, bx + 64, by, md, 1'b0);
        drive(1'b1, bx, by + 64, md, 1'b0);
        drive(1'b1, (bx == 0) ? 1055 : bx - 1, by, md, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out", 32'({o_hsync, o_vsync, o_frame, o_red, o_green, o_blue}), 32'd0);

        // Reset rows, one of them a frame event that must be ignored.
        drive(1'b0, 0, 0, 2'd0, 1'b0);
        drive(1'b0, 0, 600, 2'd2, 1'b0);
        drive(1'b1, 50, 10, 2'd0, 1'b0);
        drive(1'b1, 750, 10, 2'd0, 1'b0);

        // Colour bars, blanking and out-of-range counters.
        for (int i = 0; i < 8; i++) drive(1'b1, i * 100 + 50, 10, 2'd0, 1'b0);
        drive(1'b1, 799, 599, 2'd0, 1'b0);
        drive(1'b1, 800, 10, 2'd0, 1'b0);
        drive(1'b1, 900, 603, 2'd0, 1'b0);
        drive(1'b1, 1500, 700, 2'd0, 1'b0);
        drive(1'b1, 2047, 1023, 2'd0, 1'b0);

        // One full line: hsync width.
        hs_tally = 0;
        for (int h = 0; h < 1056; h++) drive(1'b1, h, 10, 2'd0, 1'b1);
        drive(1'b1, 0, 0, 2'd0, 1'b0);
        drive(1'b1, 0, 0, 2'd0, 1'b0);
        check_eq("hsync_per_line", 32'(hs_tally), 32'd128);

        // One column of a full frame: vsync lines and frame pulses.
        vs_tally = 0;
        fr_tally = 0;
        for (int v = 0; v < 628; v++) drive(1'b1, 0, v, 2'd0, 1'b1);
        drive(1'b1, 0, 0, 2'd0, 1'b0);
        drive(1'b1, 0, 0, 2'd0, 1'b0);
        check_eq("vsync_lines", 32'(vs_tally), 32'd4);
        check_eq("frame_pulses", 32'(fr_tally), 32'd1);

        // Mid-frame mode change has no effect until the frame event.
        drive(1'b1, 100, 300, 2'd2, 1'b0);
        drive(1'b1, 450, 450, 2'd2, 1'b0);
        drive(1'b1, 0, 0, 2'd2, 1'b0);
        drive(1'b1, 0, 600, 2'd2, 1'b0);
        probe_box(2'd2);

        // Reset mid-box.
        drive(1'b1, 400, 200, 2'd2, 1'b0);
        drive(1'b0, 400, 200, 2'd2, 1'b0);
        drive(1'b0, 400, 200, 2'd2, 1'b0);
        drive(1'b1, 400, 200, 2'd2, 1'b0);
        drive(1'b1, 400, 200, 2'd2, 1'b0);
        drive(1'b1, 0, 0, 2'd2, 1'b0);

        // 800 frames of the moving box.
        for (int f = 0; f < 800; f++) begin
            drive(1'b1, 0, 600, 2'd2, 1'b0);
            probe_box(2'd2);
            if (f == 735 || f == 736) drive(1'b1, 799, tri_pos(n_events, 536), 2'd2, 1'b0);
        end

        // Checkerboard phase over 120 frames from a fresh reset.
        drive(1'b0, 0, 0, 2'd1, 1'b0);
        drive(1'b1, 0, 0, 2'd1, 1'b0);
        for (int f = 0; f < 120; f++) begin
            drive(1'b1, 0, 600, 2'd1, 1'b0);
            drive(1'b1, 0, 0, 2'd1, 1'b0);
            drive(1'b1, 32, 0, 2'd1, 1'b0);
            drive(1'b1, 0, 32, 2'd1, 1'b0);
            drive(1'b1, 40, 40, 2'd1, 1'b0);
        end

        // Horizontal gradient.
        drive(1'b1, 0, 600, 2'd3, 1'b0);
        drive(1'b1, 0, 100, 2'd3, 1'b0);
        drive(1'b1, 63, 100, 2'd3, 1'b0);
        drive(1'b1, 64, 100, 2'd3, 1'b0);
        drive(1'b1, 500, 100, 2'd3, 1'b0);
        drive(1'b1, 767, 100, 2'd3, 1'b0);
        drive(1'b1, 799, 100, 2'd3, 1'b0);
        drive(1'b1, 800, 100, 2'd3, 1'b0);

        tick(1'b1);
        tick(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
